// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types and geometry for the D-cache miss controller.
// Holds the FSM state encoding, address geometry and address-slice helpers.
package dcache_miss_ctrl_pkg;

   localparam int ADDR_W     = 32;
   localparam int OFFSET_W   = 4;
   localparam int INDEX_W    = 5;
   localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
   localparam int BLOCK_BITS = 128;
   localparam int BADDR_W    = TAG_W + INDEX_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WB,
      S_REFILL,
      S_FILL
   } state_e;

   // {tag,index} of a byte address
   function automatic logic [BADDR_W-1:0] blk_addr(
      input logic [ADDR_W-1:0] a
   );
      return a[ADDR_W-1:OFFSET_W];
   endfunction

   // 32b word position inside the 16B block
   function automatic logic [1:0] word_sel(
      input logic [ADDR_W-1:0] a
   );
      return a[3:2];
   endfunction

endpackage

// File: rtl/dcache_word_lane.sv
// Word lane: picks a 32b word out of a block and builds store lanes.
// Ports: block_i/word_sel_i select rdata_o; byte_en_i/wdata_i give bytes_access_o, data_rep_o.
module dcache_word_lane
   import dcache_miss_ctrl_pkg::*;
(
   input  logic [BLOCK_BITS-1:0] block_i,
   input  logic [1:0]            word_sel_i,
   input  logic [3:0]            byte_en_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o,
   output logic [15:0]           bytes_access_o,
   output logic [BLOCK_BITS-1:0] data_rep_o
);

   assign rdata_o        = block_i[{word_sel_i, 5'b00000} +: 32];
   assign bytes_access_o = {12'b0, byte_en_i} << {word_sel_i, 2'b00};
   // the SRAM picks the right copy through bytes_access_o
   assign data_rep_o     = {4{wdata_i}};

endmodule

// File: rtl/dcache_miss_ctrl.sv
// D-cache controller: serves hits in the request cycle and runs writeback/refill/fill on a miss.
// Ports: cpu_* to the MEM stage, sram_* to the 2-way array, mem_* to data memory; rst is async active-low.
module dcache_miss_ctrl
   import dcache_miss_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_wen,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [3:0]            cpu_byte_en,
   input  logic [31:0]           cpu_wdata,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_stall,
   output logic                  sram_en,
   output logic                  sram_wen,
   output logic                  sram_dmemWen,
   output logic [15:0]           sram_bytesAccess,
   output logic [BADDR_W-1:0]    sram_blockAddr,
   output logic [BLOCK_BITS-1:0] sram_dataIn,
   input  logic                  sram_hit,
   input  logic                  sram_dirty,
   input  logic [TAG_W-1:0]      sram_victim_tag,
   input  logic [BLOCK_BITS-1:0] sram_dataOut,
   output logic                  mem_req,
   output logic                  mem_wen,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [BLOCK_BITS-1:0] mem_wdata,
   input  logic [BLOCK_BITS-1:0] mem_rdata,
   input  logic                  mem_ready
);

   state_e                  state_q, state_d;
   logic [BADDR_W-1:0]      addr_q, addr_d;
   logic [TAG_W-1:0]        vtag_q, vtag_d;
   logic [BLOCK_BITS-1:0]   vdata_q, vdata_d;
   logic [BLOCK_BITS-1:0]   fill_q, fill_d;

   logic [31:0]             lane_rdata;
   logic [15:0]             lane_be;
   logic [BLOCK_BITS-1:0]   lane_rep;

   // byte offset inside the word is the core's concern
   logic                    addr_lsb_unused;
   assign addr_lsb_unused = ^cpu_addr[1:0];

   dcache_word_lane u_lane (
      .block_i        (sram_dataOut),
      .word_sel_i     (word_sel(cpu_addr)),
      .byte_en_i      (cpu_byte_en),
      .wdata_i        (cpu_wdata),
      .rdata_o        (lane_rdata),
      .bytes_access_o (lane_be),
      .data_rep_o     (lane_rep)
   );

   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      vtag_d           = vtag_q;
      vdata_d          = vdata_q;
      fill_d           = fill_q;
      cpu_rdata        = '0;
      cpu_stall        = 1'b0;
      sram_en          = 1'b0;
      sram_wen         = 1'b0;
      sram_dmemWen     = 1'b0;
      sram_bytesAccess = '0;
      sram_blockAddr   = addr_q;
      sram_dataIn      = '0;
      mem_req          = 1'b0;
      mem_wen          = 1'b0;
      mem_addr         = '0;
      mem_wdata        = '0;
      unique case (state_q)
         S_IDLE: begin
            sram_en        = cpu_req;
            sram_blockAddr = blk_addr(cpu_addr);
            if (cpu_req && sram_hit) begin
               if (cpu_wen) begin
                  sram_wen         = 1'b1;
                  sram_bytesAccess = lane_be;
                  sram_dataIn      = lane_rep;
               end else begin
                  cpu_rdata = lane_rdata;
               end
            end else if (cpu_req) begin
               // victim info is only valid in this lookup cycle
               cpu_stall = 1'b1;
               addr_d    = blk_addr(cpu_addr);
               vtag_d    = sram_victim_tag;
               vdata_d   = sram_dataOut;
               state_d   = sram_dirty ? S_WB : S_REFILL;
            end
         end
         S_WB: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_wen   = 1'b1;
            mem_addr  = {vtag_q, addr_q[INDEX_W-1:0],
                         {OFFSET_W{1'b0}}};
            mem_wdata = vdata_q;
            if (mem_ready) state_d = S_REFILL;
         end
         S_REFILL: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = {addr_q, {OFFSET_W{1'b0}}};
            if (mem_ready) begin
               fill_d  = mem_rdata;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            cpu_stall        = 1'b1;
            sram_en          = 1'b1;
            sram_wen         = 1'b1;
            sram_dmemWen     = 1'b1;
            sram_bytesAccess = '1;
            sram_dataIn      = fill_q;
            state_d          = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         vtag_q  <= '0;
         vdata_q <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         vtag_q  <= vtag_d;
         vdata_q <= vdata_d;
         fill_q  <= fill_d;
      end
   end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl with a 2-way SRAM array model, a memory responder
// and a flat word-memory reference model.
module tb_dcache_miss_ctrl;
   import dcache_miss_ctrl_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cpu_req, cpu_wen;
   logic [ADDR_W-1:0]     cpu_addr;
   logic [3:0]            cpu_byte_en;
   logic [31:0]           cpu_wdata, cpu_rdata;
   logic                  cpu_stall;
   logic                  sram_en, sram_wen, sram_dmemWen;
   logic [15:0]           sram_bytesAccess;
   logic [BADDR_W-1:0]    sram_blockAddr;
   logic [BLOCK_BITS-1:0] sram_dataIn, sram_dataOut;
   logic                  sram_hit, sram_dirty;
   logic [TAG_W-1:0]      sram_victim_tag;
   logic                  mem_req, mem_wen, mem_ready;
   logic [ADDR_W-1:0]     mem_addr;
   logic [BLOCK_BITS-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dcache_miss_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_byte_en(cpu_byte_en), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .sram_en(sram_en), .sram_wen(sram_wen),
      .sram_dmemWen(sram_dmemWen), .sram_bytesAccess(sram_bytesAccess),
      .sram_blockAddr(sram_blockAddr), .sram_dataIn(sram_dataIn),
      .sram_hit(sram_hit), .sram_dirty(sram_dirty),
      .sram_victim_tag(sram_victim_tag), .sram_dataOut(sram_dataOut),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- 2-way SRAM array model ----------------
   bit [TAG_W-1:0]      s_tag [32][2];
   bit                  s_vld [32][2];
   bit                  s_dty [32][2];
   bit [BLOCK_BITS-1:0] s_dat [32][2];
   bit                  s_lru [32];
   logic [4:0]          s_idx;
   logic [TAG_W-1:0]    s_t;
   logic                s_hw, s_vw;

   always_comb begin
      s_idx    = sram_blockAddr[4:0];
      s_t      = sram_blockAddr[BADDR_W-1:5];
      sram_hit = 1'b0;
      s_hw     = 1'b0;
      for (int w = 0; w < 2; w++)
         if (s_vld[s_idx][w] && s_tag[s_idx][w] == s_t) begin
            sram_hit = 1'b1;
            s_hw     = w[0];
         end
      if (!s_vld[s_idx][0])      s_vw = 1'b0;
      else if (!s_vld[s_idx][1]) s_vw = 1'b1;
      else                       s_vw = s_lru[s_idx];
      sram_dirty      = s_vld[s_idx][s_vw] && s_dty[s_idx][s_vw];
      sram_victim_tag = s_tag[s_idx][s_vw];
      sram_dataOut    = sram_hit ? s_dat[s_idx][s_hw]
                                 : s_dat[s_idx][s_vw];
   end

   always @(posedge clk) begin
      if (sram_en && sram_wen) begin
         if (sram_dmemWen) begin
            s_tag[s_idx][s_vw] <= s_t;
            s_vld[s_idx][s_vw] <= 1'b1;
            s_dty[s_idx][s_vw] <= 1'b0;
            s_dat[s_idx][s_vw] <= sram_dataIn;
            s_lru[s_idx]       <= ~s_vw;
         end else if (sram_hit) begin
            for (int b = 0; b < 16; b++)
               if (sram_bytesAccess[b])
                  s_dat[s_idx][s_hw][8*b +: 8] <= sram_dataIn[8*b +: 8];
            s_dty[s_idx][s_hw] <= 1'b1;
            s_lru[s_idx]       <= ~s_hw;
         end
      end else if (sram_en && sram_hit) begin
         s_lru[s_idx] <= ~s_hw;
      end
   end

   // ---------------- reference model and backing memory ----------------
   bit [31:0]         ref_mem [int unsigned];
   bit [127:0]        dram    [int unsigned];

   function automatic bit [31:0] init_word(int unsigned wa);
      return (wa * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   function automatic bit [31:0] ref_get(int unsigned a);
      if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
      return init_word(a >> 2);
   endfunction

   function automatic bit [127:0] dram_get(int unsigned blk);
      bit [127:0] v;
      if (dram.exists(blk)) return dram[blk];
      for (int i = 0; i < 4; i++) v[32*i +: 32] = init_word(blk*4 + i);
      return v;
   endfunction

   // ---------------- memory responder ----------------
   int            fixed_lat = 3;
   int            cnt = 0;
   int            lat = 1;
   logic [31:0]   cap_addr;
   logic          cap_wen;
   logic [127:0]  cap_wdata;
   int unsigned   log_addr [$];
   bit            log_wen  [$];

   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ready = 1'b0;
         if (rst && mem_req) begin
            if (cnt == 0) begin
               cap_addr  = mem_addr;
               cap_wen   = mem_wen;
               cap_wdata = mem_wdata;
               lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 4);
               chk("mem_align", {124'b0, mem_addr[3:0]}, 128'd0);
            end else begin
               chk("mem_addr_hold", mem_addr, cap_addr);
               chk("mem_wen_hold", mem_wen, cap_wen);
               if (cap_wen) chk("mem_wdata_hold", mem_wdata, cap_wdata);
            end
            chk("stall_in_mem", cpu_stall, 1'b1);
            cnt++;
            if (cnt >= lat) begin
               mem_ready = 1'b1;
               if (cap_wen) dram[cap_addr >> 4] = cap_wdata;
               else mem_rdata = dram_get(cap_addr >> 4);
               log_addr.push_back(cap_addr);
               log_wen.push_back(cap_wen);
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit        st;
      bit [31:0] exp;
   } exp_t;
   exp_t sbq [$];

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && cpu_req && !cpu_stall) begin
            if (sbq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_unexpected: accept with empty queue at %0h",
                        cpu_addr);
            end else begin
               e = sbq.pop_front();
               if (e.st) begin
                  chk("st_wen", sram_wen, 1'b1);
                  chk("st_bytes", sram_bytesAccess, e.exp[15:0]);
                  chk("st_data", sram_dataIn, {4{cpu_wdata}});
               end else begin
                  chk("ld_data", cpu_rdata, e.exp);
               end
            end
         end
      end
   end

   task automatic do_op(input bit st, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int stalls);
      exp_t e;
      bit [15:0] ba;
      bit [31:0] w;
      e.st = st;
      if (st) begin
         ba = {12'b0, be};
         ba = ba << (4 * a[3:2]);
         e.exp = {16'b0, ba};
         w = ref_get(a);
         for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
         ref_mem[a >> 2] = w;
      end else begin
         e.exp = ref_get(a);
      end
      sbq.push_back(e);
      cpu_req     = 1'b1;
      cpu_wen     = st;
      cpu_addr    = a;
      cpu_byte_en = be;
      cpu_wdata   = wd;
      stalls      = 0;
      forever begin
         @(negedge clk);
         if (!cpu_stall) break;
         stalls++;
         if (stalls > 300) begin
            $display("FAIL op_timeout: stall stuck at addr %0h", a);
            $fatal(1, "timeout");
         end
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      cpu_wen = 1'b0;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int st;
      int n0;
      int k;
      bit [127:0] blk;
      rst = 1'b0;
      cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0;
      cpu_byte_en = '0; cpu_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_sram_en", {sram_en, sram_wen, sram_dmemWen}, 3'b000);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // cold load: block 0x40 words W0..W3 = 1..4
      dram[4] = {32'h4, 32'h3, 32'h2, 32'h1};
      for (int i = 0; i < 4; i++) ref_mem[32'h10 + i] = i + 1;
      fixed_lat = 3;
      n0 = log_addr.size();
      do_op(0, 32'h40, 4'hF, 0, st);
      chk("cold_stall", st, 2 + 3);
      chk("cold_ntx", log_addr.size() - n0, 1);
      chk("cold_wen", log_wen[n0], 1'b0);
      chk("cold_addr", log_addr[n0], 32'h40);

      n0 = log_addr.size();
      do_op(0, 32'h44, 4'hF, 0, st);
      chk("hit_stall", st, 0);
      chk("hit_ntx", log_addr.size() - n0, 0);

      do_op(1, 32'h48, 4'b0011, 32'hAABBCCDD, st);
      chk("sthit_stall", st, 0);
      do_op(0, 32'h48, 4'hF, 0, st);

      // fill both ways of set 4, third tag evicts the dirty 0x40 block
      do_op(0, 32'h440, 4'hF, 0, st);
      chk("way1_stall", st, 2 + 3);
      n0 = log_addr.size();
      do_op(0, 32'h840, 4'hF, 0, st);
      chk("evict_stall", st, 2 + 3 + 3);
      chk("evict_ntx", log_addr.size() - n0, 2);
      chk("wb_wen", log_wen[n0], 1'b1);
      chk("wb_addr", log_addr[n0], 32'h40);
      chk("rf_wen", log_wen[n0+1], 1'b0);
      chk("rf_addr", log_addr[n0+1], 32'h840);
      blk = dram_get(4);
      chk("wb_word2", blk[95:64], 32'h0000CCDD);
      chk("wb_word1", blk[63:32], 32'h2);
      do_op(0, 32'h48, 4'hF, 0, st);
      chk("reload_stall", st, 2 + 3);

      // long memory latency on a dirty eviction in set 7
      do_op(1, 32'h70, 4'b1100, 32'h12345678, st);
      do_op(0, 32'h470, 4'hF, 0, st);
      fixed_lat = 7;
      do_op(0, 32'h874, 4'hF, 0, st);
      chk("slow_stall", st, 2 + 7 + 7);
      do_op(0, 32'h70, 4'hF, 0, st);
      chk("slow_clean_stall", st, 2 + 7);

      // random traffic over 8 sets x 6 tags
      fixed_lat = 0;
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 5) << 9) | ($urandom_range(0, 7) << 4)
             | ($urandom_range(0, 3) << 2);
         do_op(($urandom_range(0, 2) == 0), a, 4'($urandom_range(1, 15)),
               $urandom, st);
      end

      // reset in the middle of a refill
      fixed_lat = 20;
      cpu_req = 1'b1; cpu_wen = 1'b0;
      cpu_addr = 32'h1F00; cpu_byte_en = 4'hF;
      k = 0;
      while (!(mem_req === 1'b1 && mem_wen === 1'b0) && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("rst_reach_refill", (k < 50), 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk("midrst_mem_req", mem_req, 1'b0);
      chk("midrst_stall", cpu_stall, 1'b0);
      chk("midrst_sram", {sram_en, sram_wen}, 2'b00);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      fixed_lat = 3;
      n0 = log_addr.size();
      do_op(0, 32'h1F00, 4'hF, 0, st);
      chk("midrst_remiss", log_addr.size() - n0, 1);
      chk("midrst_stall_n", st, 2 + 3);

      repeat (2) @(posedge clk);
      chk("sb_drain", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
